fmlarb_rr: RTL and testbench



---
 rtl/fmlarb_rr_pkg.sv | 22 ++
 rtl/fmlarb_rr_pick.sv | 40 ++++
 rtl/fmlarb_rr.sv | 135 +++++++++++++
 tb/tb_fmlarb_rr.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmlarb_rr_pkg.sv
// fmlarb_pkg: shared types and constants for the fmlarb_rr FML arbiter.
// Holds the arbiter state encoding, FML bus widths and a clog2 helper.
package fmlarb_pkg;

   localparam int unsigned FML_DW = 64;
   localparam int unsigned FML_SW = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_ADDR
   } arb_state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fmlarb_rr_pick.sv
// fmlarb_rr_pick: combinational rotating-priority encoder, scan starts at i_last+1.
// Build option FMLARB_RR_PRIO0_EN: master 0 wins outright and is left out of the rotation.
module fmlarb_rr_pick #(
   parameter int unsigned nmasters = 6,
   parameter int unsigned IW       = 3
) (
   input  logic [nmasters-1:0] i_req,
   input  logic [nmasters-1:0] i_mask,
   input  logic [IW-1:0]       i_last,
   output logic [IW-1:0]       o_win,
   output logic                o_valid
);

`ifdef FMLARB_RR_PRIO0_EN
   localparam logic PRIO0 = 1'b1;
`else
   localparam logic PRIO0 = 1'b0;
`endif

   logic [nmasters-1:0] w_elig;

   assign w_elig = i_req & ~i_mask;

   always_comb begin
      logic [IW-1:0] w_idx;
      o_win   = '0;
      o_valid = 1'b0;
      w_idx   = '0;
      if (PRIO0 && w_elig[0]) o_valid = 1'b1;
      // k = nmasters brings the scan back to i_last itself, so it is tried last
      for (int unsigned k = 1; k <= nmasters; k++) begin
         w_idx = IW'((32'(i_last) + k) % nmasters);
         if (!o_valid && w_elig[w_idx] && !(PRIO0 && w_idx == '0)) begin
            o_win   = w_idx;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fmlarb_rr.sv
// fmlarb_rr: registered round-robin FML arbiter, nmasters burst masters onto one slave.
// Build option FMLARB_RR_PRIO0_EN: master 0 gets absolute priority over the rotation.
module fmlarb_rr
   import fmlarb_pkg::*;
#(
   parameter int unsigned fml_depth = 26,
   parameter int unsigned nmasters  = 6,
   parameter int unsigned burst_len = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [nmasters*fml_depth-1:0] m_adr,
   input  logic [nmasters-1:0]           m_stb,
   input  logic [nmasters-1:0]           m_we,
   input  logic [nmasters*FML_SW-1:0]    m_sel,
   input  logic [nmasters*FML_DW-1:0]    m_di,
   output logic [nmasters-1:0]           m_ack,
   output logic [FML_DW-1:0]             m_do,
   output logic [fml_depth-1:0]          s_adr,
   output logic                          s_stb,
   output logic                          s_we,
   input  logic                          s_ack,
   output logic [FML_SW-1:0]             s_sel,
   output logic [FML_DW-1:0]             s_do,
   input  logic [FML_DW-1:0]             s_di
);

   localparam int unsigned IW = (clog2(nmasters) > 1) ? clog2(nmasters) : 1;
   localparam int unsigned CW = clog2(burst_len);
   localparam logic [nmasters-1:0] ONE = nmasters'(1);

`ifdef FMLARB_RR_PRIO0_EN
   localparam logic PRIO0 = 1'b1;
`else
   localparam logic PRIO0 = 1'b0;
`endif

   arb_state_t           r_state, w_state_nxt;
   logic [IW-1:0]        r_g, r_last, r_wmaster, w_win, w_dsel;
   logic [CW-1:0]        r_wcnt;
   logic [fml_depth-1:0] r_adr, w_win_adr;
   logic                 r_stb, r_we, w_win_we, w_valid, w_ack_ev, w_load;
   logic [nmasters-1:0]  w_ack_vec;

   assign w_ack_ev  = (r_state == ARB_ADDR) && s_ack;
   assign w_ack_vec = w_ack_ev ? (ONE << r_g) : '0;
   assign m_ack     = w_ack_vec;
   assign m_do      = s_di;
   assign s_adr     = r_adr;
   assign s_stb     = r_stb;
   assign s_we      = r_we;

   // The acked master doubles as the mask, so it cannot be re-granted in its ack cycle
   fmlarb_rr_pick #(
      .nmasters (nmasters),
      .IW       (IW)
   ) u_pick (
      .i_req   (m_stb),
      .i_mask  (w_ack_vec),
      .i_last  (r_last),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= ARB_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ARB_ADDR;
            end
         end
         ARB_ADDR: begin
            if (s_ack) begin
               if (w_valid) w_load      = 1'b1;
               else         w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Write beats after the ack cycle follow wmaster; beat 0 and reads follow g
   always_comb begin
      w_win_adr = '0;
      w_win_we  = 1'b0;
      s_do      = '0;
      s_sel     = '0;
      w_dsel    = (r_wcnt != '0) ? r_wmaster : r_g;
      for (int unsigned i = 0; i < nmasters; i++) begin
         if (w_win == IW'(i)) begin
            w_win_adr = m_adr[i*fml_depth +: fml_depth];
            w_win_we  = m_we[i];
         end
         if (w_dsel == IW'(i)) begin
            s_do  = m_di[i*FML_DW +: FML_DW];
            s_sel = m_sel[i*FML_SW +: FML_SW];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_g       <= '0;
         r_last    <= IW'(nmasters - 1);
         r_adr     <= '0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_wmaster <= '0;
         r_wcnt    <= '0;
      end else begin
         r_stb <= (w_state_nxt == ARB_ADDR);
         if (w_load) begin
            r_g   <= w_win;
            r_adr <= w_win_adr;
            r_we  <= w_win_we;
         end
         if (w_ack_ev && !(PRIO0 && r_g == '0)) r_last <= r_g;
         if (w_ack_ev && r_we) begin
            r_wmaster <= r_g;
            r_wcnt    <= CW'(burst_len - 1);
         end else if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fmlarb_rr.sv
// tb_fmlarb_rr: directed bench for fmlarb_rr at (6 masters, burst 4), (16, 8) and (2, 2).
// Expectations switch where FMLARB_RR_PRIO0_EN changes the grant order.
module tb_fmlarb_rr;

   localparam int unsigned AD = 26;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // instance A: 6 masters, burst 4
   logic [6*AD-1:0]  a_adr;
   logic [5:0]       a_stb, a_we, a_ack;
   logic [47:0]      a_sel;
   logic [383:0]     a_di;
   logic [63:0]      a_mdo, a_sdo, a_sdi;
   logic [AD-1:0]    a_sadr;
   logic             a_sstb, a_swe, a_sack;
   logic [7:0]       a_ssel;
   // instance B: 16 masters, burst 8
   logic [16*AD-1:0] b_adr;
   logic [15:0]      b_stb, b_we, b_ack;
   logic [127:0]     b_sel;
   logic [1023:0]    b_di;
   logic [63:0]      b_mdo, b_sdo, b_sdi;
   logic [AD-1:0]    b_sadr;
   logic             b_sstb, b_swe, b_sack;
   logic [7:0]       b_ssel;
   // instance C: 2 masters, burst 2
   logic [2*AD-1:0]  c_adr;
   logic [1:0]       c_stb, c_we, c_ack;
   logic [15:0]      c_sel;
   logic [127:0]     c_di;
   logic [63:0]      c_mdo, c_sdo, c_sdi;
   logic [AD-1:0]    c_sadr;
   logic             c_sstb, c_swe, c_sack;
   logic [7:0]       c_ssel;

   fmlarb_rr #(.fml_depth(AD), .nmasters(6), .burst_len(4)) u_dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(a_adr), .m_stb(a_stb), .m_we(a_we),
      .m_sel(a_sel), .m_di(a_di), .m_ack(a_ack), .m_do(a_mdo), .s_adr(a_sadr),
      .s_stb(a_sstb), .s_we(a_swe), .s_ack(a_sack), .s_sel(a_ssel), .s_do(a_sdo), .s_di(a_sdi));

   fmlarb_rr #(.fml_depth(AD), .nmasters(16), .burst_len(8)) u_dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(b_adr), .m_stb(b_stb), .m_we(b_we),
      .m_sel(b_sel), .m_di(b_di), .m_ack(b_ack), .m_do(b_mdo), .s_adr(b_sadr),
      .s_stb(b_sstb), .s_we(b_swe), .s_ack(b_sack), .s_sel(b_ssel), .s_do(b_sdo), .s_di(b_sdi));

   fmlarb_rr #(.fml_depth(AD), .nmasters(2), .burst_len(2)) u_dut_c (
      .sys_clk(clk), .sys_rst_n(rst_n), .m_adr(c_adr), .m_stb(c_stb), .m_we(c_we),
      .m_sel(c_sel), .m_di(c_di), .m_ack(c_ack), .m_do(c_mdo), .s_adr(c_sadr),
      .s_stb(c_sstb), .s_we(c_swe), .s_ack(c_sack), .s_sel(c_ssel), .s_do(c_sdo), .s_di(c_sdi));

   function automatic logic [63:0] dat(input int unsigned i);
      return (64'h0101_0101_0101_0101 * 64'(i + 1)) ^ 64'hF00D_0000_0000_0000;
   endfunction

   function automatic logic [63:0] adr(input int unsigned i);
      return 64'(32'h40 * (i + 1));
   endfunction

   function automatic logic [63:0] sel(input int unsigned i);
      return 64'(i + 16);
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      for (int i = 0; i < 16; i++) begin
         b_adr[i*AD +: AD] = AD'(adr(i));
         b_di[i*64 +: 64]  = dat(i);
         b_sel[i*8 +: 8]   = 8'(sel(i));
         if (i < 6) begin
            a_adr[i*AD +: AD] = AD'(adr(i));
            a_di[i*64 +: 64]  = dat(i);
            a_sel[i*8 +: 8]   = 8'(sel(i));
         end
         if (i < 2) begin
            c_adr[i*AD +: AD] = AD'(adr(i));
            c_di[i*64 +: 64]  = dat(i);
            c_sel[i*8 +: 8]   = 8'(sel(i));
         end
      end
      a_sdi = 64'h0; b_sdi = 64'h0; c_sdi = 64'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      a_stb = '0; a_we = '0; a_sack = 1'b0;
      b_stb = '0; b_we = '0; b_sack = 1'b0;
      c_stb = '0; c_we = '0; c_sack = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();
   endtask

   // Grant already visible: check it, hold address two cycles, then ack for one cycle
   task automatic a_grant(input int unsigned idx, input string tag);
      check_eq({tag, " stb"}, 64'(a_sstb), 64'd1);
      check_eq({tag, " adr"}, 64'(a_sadr), adr(idx));
      step();
      step();
      a_sack = 1'b1;
      #1;
      check_eq({tag, " ack"}, 64'(a_ack), 64'd1 << idx);
      step();
      a_sack = 1'b0;
   endtask

   task automatic b_grant(input int unsigned idx, input string tag);
      check_eq({tag, " stb"}, 64'(b_sstb), 64'd1);
      check_eq({tag, " adr"}, 64'(b_sadr), adr(idx));
      step();
      b_sack = 1'b1;
      #1;
      check_eq({tag, " ack"}, 64'(b_ack), 64'd1 << idx);
      step();
      b_sack = 1'b0;
   endtask

`ifdef FMLARB_RR_PRIO0_EN
   int unsigned b_exp[4] = '{0, 14, 0, 15};
`else
   int unsigned b_exp[4] = '{0, 14, 15, 0};
`endif
   int unsigned a_fair[6] = '{1, 2, 4, 1, 2, 4};
   int unsigned a_prio[4] = '{0, 5, 0, 5};

   initial begin
      init_inputs();
      do_reset();
      check_eq("rst s_stb", 64'(a_sstb), 64'd0);
      check_eq("rst s_adr", 64'(a_sadr), 64'd0);
      check_eq("rst s_we",  64'(a_swe),  64'd0);
      check_eq("rst m_ack", 64'(a_ack),  64'd0);

      // single read from master 3
      a_stb[3] = 1'b1;
      step();
      check_eq("rd stb", 64'(a_sstb), 64'd1);
      check_eq("rd adr", 64'(a_sadr), 64'h100);
      check_eq("rd we",  64'(a_swe),  64'd0);
      step();
      check_eq("rd hold", 64'(a_sstb), 64'd1);
      a_sack = 1'b1;
      a_sdi  = 64'hDEAD_BEEF_0123_4567;
      #1;
      check_eq("rd ack",  64'(a_ack), 64'b001000);
      check_eq("rd m_do", a_mdo, 64'hDEAD_BEEF_0123_4567);
      step();
      a_sack = 1'b0;
      a_stb  = '0;
      #1;
      check_eq("rd idle stb", 64'(a_sstb), 64'd0);
      check_eq("rd idle ack", 64'(a_ack),  64'd0);

      // fairness among 1, 2, 4 with no idle cycles between grants
      do_reset();
      a_stb = 6'b010110;
      step();
      for (int k = 0; k < 6; k++) a_grant(a_fair[k], $sformatf("fair%0d", k));

      // masters 0 and 5 alternate in both builds
      do_reset();
      a_stb = 6'b100001;
      step();
      for (int k = 0; k < 4; k++) a_grant(a_prio[k], $sformatf("prio%0d", k));

      // write burst from master 2, master 1 granted on the ack cycle
      do_reset();
      a_we[2]  = 1'b1;
      a_stb[2] = 1'b1;
      step();
      check_eq("wr we",  64'(a_swe),  64'd1);
      check_eq("wr adr", 64'(a_sadr), adr(2));
      a_stb[1] = 1'b1;
      step();
      a_sack = 1'b1;
      #1;
      check_eq("wr beat0", a_sdo, dat(2));
      check_eq("wr sel0",  64'(a_ssel), sel(2));
      step();
      a_sack   = 1'b0;
      a_stb[2] = 1'b0;
      a_we[2]  = 1'b0;
      check_eq("wr next adr", 64'(a_sadr), adr(1));
      check_eq("wr next stb", 64'(a_sstb), 64'd1);
      for (int k = 1; k < 4; k++) begin
         #1;
         check_eq($sformatf("wr beat%0d", k), a_sdo, dat(2));
         step();
      end
      #1;
      check_eq("wr switch do",  a_sdo, dat(1));
      check_eq("wr switch sel", 64'(a_ssel), sel(1));

      // async reset while in ADDR with ack high; scan pointer must return to master 0
      do_reset();
      a_stb = 6'b001001;
      step();
      a_grant(0, "ar g0");
      a_stb[0] = 1'b0;
      check_eq("ar g3 adr", 64'(a_sadr), adr(3));
      a_sack = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("ar stb", 64'(a_sstb), 64'd0);
      check_eq("ar ack", 64'(a_ack),  64'd0);
      check_eq("ar adr", 64'(a_sadr), 64'd0);
      a_sack = 1'b0;
      a_stb  = 6'b010001;
      #2 rst_n = 1'b1;
      step();
      check_eq("ar rescan", 64'(a_sadr), adr(0));

      // 16 masters: pointer wrap 15 -> 0
      do_reset();
      b_stb = 16'hC001;
      step();
      for (int k = 0; k < 4; k++) b_grant(b_exp[k], $sformatf("wrap%0d", k));

      // 16 masters, burst 8: write counter loads 7
      do_reset();
      b_we[3]  = 1'b1;
      b_stb[3] = 1'b1;
      step();
      b_stb[5] = 1'b1;
      step();
      b_sack = 1'b1;
      #1;
      check_eq("b8 beat0", b_sdo, dat(3));
      step();
      b_sack   = 1'b0;
      b_stb[3] = 1'b0;
      b_we[3]  = 1'b0;
      for (int k = 1; k < 8; k++) begin
         #1;
         check_eq($sformatf("b8 beat%0d", k), b_sdo, dat(3));
         step();
      end
      #1;
      check_eq("b8 switch", b_sdo, dat(5));

      // 2 masters, burst 2: counter loads 1, pointer wraps 1 -> 0
      do_reset();
      c_we[1]  = 1'b1;
      c_stb[1] = 1'b1;
      step();
      check_eq("c2 adr1", 64'(c_sadr), adr(1));
      c_stb[0] = 1'b1;
      step();
      c_sack = 1'b1;
      #1;
      check_eq("c2 ack",   64'(c_ack), 64'b10);
      check_eq("c2 beat0", c_sdo, dat(1));
      step();
      c_sack   = 1'b0;
      c_stb[1] = 1'b0;
      c_we[1]  = 1'b0;
      #1;
      check_eq("c2 adr0",  64'(c_sadr), adr(0));
      check_eq("c2 beat1", c_sdo, dat(1));
      step();
      #1;
      check_eq("c2 switch", c_sdo, dat(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
